pio_hex_display: RTL and testbench

- Downstream consumer of the 32-bit PIO output word on the DE10-Lite Qsys system.
- Decodes the word into six active-low seven-segment digit drives, HEX0..HEX5.
- Supports hex mode and decimal mode. Decimal mode uses a sequential shift-add-3 (double-dabble) binary-to-BCD converter.
- Also supports leading-zero blanking, per-digit decimal points and overflow indication.

---
 rtl/pio_hex_display_if.sv | 21 ++
 rtl/pio_hex_display.sv | 165 ++++++++++++++++
 tb/tb_pio_hex_display.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/pio_hex_display_if.sv
// PIO word in, six seven-segment digit drives and busy flag out.
interface pio_hex_display_if;
  logic [31:0] pio_in;
  logic [7:0]  hex0;
  logic [7:0]  hex1;
  logic [7:0]  hex2;
  logic [7:0]  hex3;
  logic [7:0]  hex4;
  logic [7:0]  hex5;
  logic        busy;

  modport master (
    output pio_in,
    input  hex0, hex1, hex2, hex3, hex4, hex5, busy
  );

  modport slave (
    input  pio_in,
    output hex0, hex1, hex2, hex3, hex4, hex5, busy
  );
endinterface

// File: rtl/pio_hex_display.sv
// Decodes the PIO control/value word onto six active-low seven-segment
// digits. Hex mode shows value nibbles directly; decimal mode runs a
// sequential shift-add-3 binary-to-BCD conversion first. Supports
// leading-zero blanking, per-digit decimal points and overflow dashes.
module pio_hex_display #(
  parameter int unsigned BIN_WIDTH = 20
) (
  input  logic              clk,
  input  logic              reset,
  pio_hex_display_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(BIN_WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_LATCH
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [31:0]          r_pio_q;
  logic [31:0]          r_snap;
  logic                 r_pend;
  logic [23:0]          r_bcd;
  logic [BIN_WIDTH-1:0] r_bin;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_busy;
  logic [7:0]           r_hex [6];
  logic [23:0]          w_adj;
  logic [7:0]           w_seg [6];
  logic                 w_dec;
  logic                 w_ovf;
  logic                 w_zero;
  logic [3:0]           w_nib;
  int unsigned          w_k;

  function automatic logic [7:0] f_glyph(input logic [3:0] n);
    case (n)
      4'h0: f_glyph = 8'hC0;
      4'h1: f_glyph = 8'hF9;
      4'h2: f_glyph = 8'hA4;
      4'h3: f_glyph = 8'hB0;
      4'h4: f_glyph = 8'h99;
      4'h5: f_glyph = 8'h92;
      4'h6: f_glyph = 8'h82;
      4'h7: f_glyph = 8'hF8;
      4'h8: f_glyph = 8'h80;
      4'h9: f_glyph = 8'h90;
      4'hA: f_glyph = 8'h88;
      4'hB: f_glyph = 8'h83;
      4'hC: f_glyph = 8'hC6;
      4'hD: f_glyph = 8'hA1;
      4'hE: f_glyph = 8'h86;
      default: f_glyph = 8'h8E;
    endcase
  endfunction

  // Register the incoming PIO word every cycle.
  always_ff @(posedge clk) begin
    if (reset) r_pio_q <= '0;
    else       r_pio_q <= bus.pio_in;
  end

  // State register; busy follows the state that is being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != S_IDLE);
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (r_pend || (r_pio_q != r_snap)) w_next = S_LOAD;
      S_LOAD:  w_next = r_pio_q[30] ? S_SHIFT : S_LATCH;
      S_SHIFT: if (r_cnt == CNT_W'(BIN_WIDTH - 1)) w_next = S_LATCH;
      S_LATCH: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Add-3 correction of every BCD nibble ahead of the shift.
  always_comb begin
    w_adj = r_bcd;
    for (int unsigned i = 0; i < 6; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
  end

  // Snapshot capture and double-dabble shift datapath.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_snap <= '0;
      r_pend <= 1'b1;
      r_bcd  <= '0;
      r_bin  <= '0;
      r_cnt  <= '0;
    end else begin
      case (r_state)
        S_LOAD: begin
          r_snap <= r_pio_q;
          r_pend <= 1'b0;
          r_bin  <= r_pio_q[BIN_WIDTH-1:0];
          r_bcd  <= '0;
          r_cnt  <= '0;
        end
        S_SHIFT: begin
          r_bcd <= {w_adj[22:0], r_bin[BIN_WIDTH-1]};
          r_bin <= {r_bin[BIN_WIDTH-2:0], 1'b0};
          r_cnt <= r_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Segment decode, scanned from the top digit down so the running
  // all-zero flag tells each digit whether it is a leading zero.
  always_comb begin
    w_dec  = r_snap[30];
    w_ovf  = w_dec && (r_snap[19:0] > 20'd999999);
    w_zero = 1'b1;
    w_nib  = '0;
    w_k    = 0;
    for (int unsigned i = 0; i < 6; i++) w_seg[i] = 8'hFF;
    for (int unsigned i = 0; i < 6; i++) begin
      w_k = 5 - i;
      if (w_dec)        w_nib = r_bcd[4*w_k +: 4];
      else if (w_k == 5) w_nib = 4'd0;
      else              w_nib = r_snap[4*w_k +: 4];
      w_zero = w_zero && (w_nib == 4'd0);
      if (w_ovf)                              w_seg[w_k] = 8'hBF;
      else if (!w_dec && (w_k == 5))          w_seg[w_k] = 8'hFF;
      else if (r_snap[31] && w_zero && (w_k != 0)) w_seg[w_k] = 8'hFF;
      else                                    w_seg[w_k] = f_glyph(w_nib);
      if (r_snap[24 + w_k]) w_seg[w_k][7] = 1'b0;
    end
  end

  // Output registers update only in LATCH.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < 6; i++) r_hex[i] <= 8'hFF;
    end else if (r_state == S_LATCH) begin
      for (int unsigned i = 0; i < 6; i++) r_hex[i] <= w_seg[i];
    end
  end

  assign bus.hex0 = r_hex[0];
  assign bus.hex1 = r_hex[1];
  assign bus.hex2 = r_hex[2];
  assign bus.hex3 = r_hex[3];
  assign bus.hex4 = r_hex[4];
  assign bus.hex5 = r_hex[5];
  assign bus.busy = r_busy;

endmodule

// File: tb/tb_pio_hex_display.sv
// Bench for pio_hex_display: directed scenarios plus randomized words
// checked against an arithmetic display model.
module tb_pio_hex_display;

  logic clk;
  logic reset;
  int unsigned checks;
  int unsigned failures;
  logic [47:0] prev_exp;
  logic [31:0] last_word;
  logic [7:0]  glyph [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                              8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  pio_hex_display_if u_if ();

  pio_hex_display #(.BIN_WIDTH(20)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [47:0] hexw();
    return {u_if.hex5, u_if.hex4, u_if.hex3, u_if.hex2, u_if.hex1, u_if.hex0};
  endfunction

  // Expected {hex5..hex0} for a control word, from the display rules.
  function automatic logic [47:0] model(input logic [31:0] w);
    int unsigned v;
    int unsigned t;
    int unsigned d [6];
    int unsigned hi;
    logic [7:0]  seg;
    logic [47:0] r;
    v = w[19:0];
    r = '0;
    if (w[30] && v > 999999) begin
      for (int unsigned k = 0; k < 6; k++) begin
        seg = 8'hBF;
        if (w[24 + k]) seg[7] = 1'b0;
        r[8*k +: 8] = seg;
      end
      return r;
    end
    t = v;
    for (int unsigned k = 0; k < 6; k++) begin
      if (w[30]) begin
        d[k] = t % 10;
        t = t / 10;
      end else begin
        d[k] = (k < 5) ? ((v >> (4 * k)) % 16) : 0;
      end
    end
    hi = 0;
    for (int unsigned k = 0; k < 6; k++) if (d[k] != 0) hi = k;
    for (int unsigned k = 0; k < 6; k++) begin
      seg = glyph[d[k]];
      if (!w[30] && k == 5) seg = 8'hFF;
      else if (w[31] && k > hi) seg = 8'hFF;
      if (w[24 + k]) seg[7] = 1'b0;
      r[8*k +: 8] = seg;
    end
    return r;
  endfunction

  // Called just after edge N (the capture edge); follows the conversion to N+lat.
  task automatic wait_conv(input int unsigned lat, input logic [47:0] e, input string tag);
    int unsigned nb;
    nb = 0;
    for (int unsigned i = 1; i <= lat; i++) begin
      @(posedge clk); #1;
      if (u_if.busy) nb++;
      if (i == lat - 1) check({tag, "_hold"}, hexw(), prev_exp);
    end
    check({tag, "_out"}, hexw(), e);
    check({tag, "_busyend"}, u_if.busy, 1'b0);
    check({tag, "_busycyc"}, nb, lat - 1);
    prev_exp = e;
  endtask

  task automatic run_word(input logic [31:0] w, input logic [47:0] e, input string tag);
    @(negedge clk);
    u_if.pio_in = w;
    @(posedge clk);
    wait_conv(w[30] ? 23 : 3, e, tag);
    last_word = w;
  endtask

  initial begin
    logic [31:0] rw;
    int unsigned v;
    logic [31:0] w;
    checks = 0;
    failures = 0;
    reset = 1'b1;
    u_if.pio_in = '0;

    // Reset for three cycles.
    for (int unsigned i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rst_hex", hexw(), 48'hFFFFFFFFFFFF);
      check("rst_busy", u_if.busy, 1'b0);
    end
    reset = 1'b0;
    prev_exp = 48'hFFFFFFFFFFFF;
    wait_conv(3, 48'hFFC0C0C0C0C0, "rst_first");
    last_word = '0;

    run_word(32'h4001E240, 48'hF9A4B0999282, "dec123456");
    run_word(32'h000ABCDE, 48'hFF8883C6A186, "hexABCDE");
    run_word(32'hC0000007, 48'hFFFFFFFFFFF8, "blank7");
    run_word(32'h41000000, 48'hC0C0C0C0C040, "dp0_zero");
    run_word(32'h400F4240, 48'hBFBFBFBFBFBF, "ovf");
    run_word(32'h500F4240, 48'hBF3FBFBFBFBF, "ovf_dp4");

    // New word arriving mid-conversion is picked up afterwards.
    @(negedge clk);
    u_if.pio_in = 32'h4001E240;
    @(posedge clk);
    for (int unsigned i = 1; i <= 46; i++) begin
      @(posedge clk); #1;
      if (i == 4)  u_if.pio_in = 32'h40000007;
      if (i == 23) check("chain_first", hexw(), 48'hF9A4B0999282);
      if (i == 23) check("chain_gap", u_if.busy, 1'b0);
      if (i == 24) check("chain_rebusy", u_if.busy, 1'b1);
      if (i == 45) check("chain_hold", hexw(), 48'hF9A4B0999282);
      if (i == 46) check("chain_second", hexw(), 48'hC0C0C0C0C0F8);
      if (i == 46) check("chain_idle", u_if.busy, 1'b0);
    end
    prev_exp = 48'hC0C0C0C0C0F8;

    // Reset during SHIFT aborts, then the conversion restarts.
    @(negedge clk);
    u_if.pio_in = 32'h4001E240;
    @(posedge clk);
    repeat (11) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_hex", hexw(), 48'hFFFFFFFFFFFF);
    check("midrst_busy", u_if.busy, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    prev_exp = 48'hFFFFFFFFFFFF;
    wait_conv(23, 48'hF9A4B0999282, "midrst_restart");
    last_word = 32'h4001E240;

    // Randomized words against the model.
    for (int unsigned n = 0; n < 40; n++) begin
      rw = $urandom;
      case ($urandom_range(0, 3))
        0:       v = $urandom_range(0, 99);
        1:       v = $urandom_range(999990, 1048575);
        default: v = $urandom_range(0, 1048575);
      endcase
      w = {rw[31:20], v[19:0]};
      if (w == last_word) w[0] = ~w[0];
      run_word(w, model(w), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
